// File: rtl/flash_read_if.sv
// Signal bundle between flash_read, its user-side read port and the spi_master
// byte handshake. The controller uses the master modport.
interface flash_read_if;
    logic        rden;
    logic [23:0] rdaddr;
    logic [7:0]  rdlen;
    logic [7:0]  rddata;
    logic        rddata_vld;
    logic        rdbusy;
    logic        rddone;
    logic        rdfail;
    logic        done;
    logic [7:0]  dout;
    logic        req;
    logic [7:0]  din;
    logic        finish;

    modport master (
        input  rden, rdaddr, rdlen, done, dout,
        output rddata, rddata_vld, rdbusy, rddone, rdfail, req, din, finish
    );

    modport slave (
        output rden, rdaddr, rdlen, done, dout,
        input  rddata, rddata_vld, rdbusy, rddone, rdfail, req, din, finish
    );
endinterface

// File: rtl/flash_read.sv
// SPI NOR READ DATA (0x03) sequencer: command, 24-bit address, then rdlen data
// bytes clocked through spi_master's req/done handshake, with per-byte timeout.
module flash_read #(
    parameter logic [7:0]  CMD_READ   = 8'h03,
    parameter logic [7:0]  DUMMY_BYTE = 8'h00,
    parameter int unsigned TIMEOUT    = 1024
) (
    input logic          clk,
    input logic          rst_n,
    flash_read_if.master bus
);
    localparam int unsigned       WCNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, END} state_t;

    state_t            state_q;
    logic              wait_q;
    logic [23:0]       addr_q;
    logic [8:0]        remain_q;
    logic [1:0]        idx_q;
    logic [WCNT_W-1:0] wcnt_q;
    logic              req_q;
    logic              finish_q;
    logic              vld_q;
    logic              rddone_q;
    logic              rdfail_q;
    logic              busy_q;
    logic [7:0]        din_q;
    logic [7:0]        rddata_q;

    assign bus.req        = req_q;
    assign bus.din        = din_q;
    assign bus.finish     = finish_q;
    assign bus.rddata     = rddata_q;
    assign bus.rddata_vld = vld_q;
    assign bus.rddone     = rddone_q;
    assign bus.rdfail     = rdfail_q;
    assign bus.rdbusy     = busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wait_q   <= 1'b0;
            addr_q   <= '0;
            remain_q <= '0;
            idx_q    <= '0;
            wcnt_q   <= '0;
            req_q    <= 1'b0;
            finish_q <= 1'b0;
            vld_q    <= 1'b0;
            rddone_q <= 1'b0;
            rdfail_q <= 1'b0;
            busy_q   <= 1'b0;
            din_q    <= '0;
            rddata_q <= '0;
        end else begin
            req_q    <= 1'b0;
            vld_q    <= 1'b0;
            rddone_q <= 1'b0;
            rdfail_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    finish_q <= 1'b0;
                    if (bus.rden) begin
                        addr_q   <= bus.rdaddr;
                        remain_q <= (bus.rdlen == 8'd0) ? 9'd256 : {1'b0, bus.rdlen};
                        busy_q   <= 1'b1;
                        req_q    <= 1'b1;
                        din_q    <= CMD_READ;
                        wait_q   <= 1'b0;
                        state_q  <= CMD;
                    end
                end

                END: begin
                    rddone_q <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end

                default: begin
                    // wait_q==0 is the req (SEND) cycle; done is only honoured in WAIT.
                    if (!wait_q) begin
                        wait_q <= 1'b1;
                        wcnt_q <= '0;
                    end else if (bus.done) begin
                        wait_q <= 1'b0;
                        if (state_q == CMD) begin
                            idx_q   <= 2'd0;
                            din_q   <= addr_q[23:16];
                            req_q   <= 1'b1;
                            state_q <= ADDR;
                        end else if (state_q == ADDR) begin
                            req_q <= 1'b1;
                            if (idx_q == 2'd2) begin
                                din_q    <= DUMMY_BYTE;
                                finish_q <= (remain_q == 9'd1);
                                state_q  <= DATA;
                            end else begin
                                idx_q <= idx_q + 2'd1;
                                din_q <= (idx_q == 2'd0) ? addr_q[15:8] : addr_q[7:0];
                            end
                        end else begin
                            rddata_q <= bus.dout;
                            vld_q    <= 1'b1;
                            remain_q <= remain_q - 9'd1;
                            if (remain_q == 9'd1) begin
                                finish_q <= 1'b0;
                                state_q  <= END;
                            end else begin
                                req_q    <= 1'b1;
                                din_q    <= DUMMY_BYTE;
                                finish_q <= (remain_q == 9'd2);
                            end
                        end
                    end else if (wcnt_q == WCNT_LAST) begin
                        // Abort: finish pulses with rdfail so spi_master drops cs.
                        rdfail_q <= 1'b1;
                        finish_q <= 1'b1;
                        busy_q   <= 1'b0;
                        wait_q   <= 1'b0;
                        state_q  <= IDLE;
                    end else begin
                        wcnt_q <= wcnt_q + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_flash_read.sv
// Self-checking bench for flash_read: randomized spi_master stub plus a
// transaction-level model of the expected byte stream, timing and status pulses.
module tb_flash_read;
    localparam int         TIMEOUT    = 1024;
    localparam logic [7:0] CMD_READ   = 8'h03;
    localparam logic [7:0] DUMMY_BYTE = 8'h00;

    logic clk = 1'b0;
    logic rst_n;

    flash_read_if bus();

    flash_read #(
        .CMD_READ  (CMD_READ),
        .DUMMY_BYTE(DUMMY_BYTE),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nchk  = 0;
    int npass = 0;

    // Logs appended by the monitor
    logic [7:0] din_log[$];
    logic       fin_log[$];
    int         req_cyc[$];
    logic [7:0] vld_log[$];
    int         vld_cyc[$];
    int         n_done_total = 0;
    int         n_fail_total = 0;
    int         last_done_cyc = 0;
    int         last_fail_cyc = 0;
    logic       busy_at_done = 1'b0;
    logic       busy_at_fail = 1'b0;
    logic       fin_at_fail  = 1'b0;

    // Logs appended by the spi_master stub
    logic [7:0] dout_log[$];
    int         done_cyc[$];
    logic [7:0] hold_din[$];
    logic       hold_fin[$];
    int         req_n = 0;
    int         spur_seen = 0;

    // Controls written only by the main sequence
    int withhold_at = -1;
    int spur_cnt = 0;

    // Per-transaction base indices
    int bq, bd, bv, bdn, bfl, rcyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] outs();
        return {10'd0, bus.req, bus.finish, bus.rddata_vld, bus.rddone, bus.rdfail,
                bus.rdbusy, bus.din, bus.rddata};
    endfunction

    function automatic logic [7:0] exp_din(input logic [23:0] a, input int i);
        case (i)
            0:       return CMD_READ;
            1:       return a[23:16];
            2:       return a[15:8];
            3:       return a[7:0];
            default: return DUMMY_BYTE;
        endcase
    endfunction

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (bus.req === 1'b1) begin
                din_log.push_back(bus.din);
                fin_log.push_back(bus.finish);
                req_cyc.push_back(cyc);
            end
            if (bus.rddata_vld === 1'b1) begin
                vld_log.push_back(bus.rddata);
                vld_cyc.push_back(cyc);
            end
            if (bus.rddone === 1'b1) begin
                n_done_total++;
                last_done_cyc = cyc;
                busy_at_done  = bus.rdbusy;
            end
            if (bus.rdfail === 1'b1) begin
                n_fail_total++;
                last_fail_cyc = cyc;
                busy_at_fail  = bus.rdbusy;
                fin_at_fail   = bus.finish;
            end
        end
    end

    initial begin : stub
        int cnt;
        cnt = -1;
        bus.done = 1'b0;
        bus.dout = 8'h00;
        forever begin
            @(negedge clk);
            bus.done = 1'b0;
            if (rst_n !== 1'b1) begin
                cnt = -1;
            end else begin
                if (cnt > 0) cnt--;
                if (cnt == 0) begin
                    bus.dout = 8'($urandom);
                    bus.done = 1'b1;
                    dout_log.push_back(bus.dout);
                    done_cyc.push_back(cyc);
                    hold_din.push_back(bus.din);
                    hold_fin.push_back(bus.finish);
                    cnt = -1;
                end else if (spur_cnt != spur_seen) begin
                    spur_seen = spur_cnt;
                    bus.dout  = 8'h5A;
                    bus.done  = 1'b1;
                end
                if (bus.req === 1'b1) begin
                    req_n++;
                    if (req_n != withhold_at) cnt = int'($urandom_range(1, 4));
                end
            end
        end
    end

    task automatic snap();
        bq  = din_log.size();
        bd  = dout_log.size();
        bv  = vld_log.size();
        bdn = n_done_total;
        bfl = n_fail_total;
    endtask

    task automatic start_read(input logic [23:0] a, input logic [7:0] l);
        snap();
        @(negedge clk);
        bus.rden   = 1'b1;
        bus.rdaddr = a;
        bus.rdlen  = l;
        rcyc       = cyc;
        @(negedge clk);
        bus.rden = 1'b0;
    endtask

    task automatic wait_end(input string nm, input int budget);
        bit seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            #1;
            seen = (n_done_total != bdn) || (n_fail_total != bfl);
        end
        chk({nm, ".end_reached"}, 32'(seen), 32'd1);
        repeat (6) @(negedge clk);
        #1;
    endtask

    task automatic verify_read(input string nm, input logic [23:0] a, input logic [7:0] l);
        int n, tot;
        n   = (l == 8'd0) ? 256 : int'(l);
        tot = n + 4;
        chk({nm, ".nreq"}, din_log.size() - bq, tot);
        chk({nm, ".ndone_in"}, dout_log.size() - bd, tot);
        for (int i = 0; i < tot && bq + i < din_log.size(); i++) begin
            chk({nm, ".din"}, din_log[bq+i], exp_din(a, i));
            chk({nm, ".finish"}, fin_log[bq+i], 32'(i == tot - 1));
        end
        for (int i = 0; i < tot && bd + i < dout_log.size(); i++) begin
            chk({nm, ".din_hold"}, hold_din[bd+i], exp_din(a, i));
            chk({nm, ".fin_hold"}, hold_fin[bd+i], 32'(i == tot - 1));
            if (i + 1 < tot && bq + i + 1 < req_cyc.size())
                chk({nm, ".req_lat"}, req_cyc[bq+i+1], done_cyc[bd+i] + 1);
        end
        if (req_cyc.size() > bq) chk({nm, ".first_req_lat"}, req_cyc[bq], rcyc + 1);
        chk({nm, ".nvld"}, vld_log.size() - bv, n);
        for (int k = 0; k < n && bv + k < vld_log.size() && bd + 4 + k < dout_log.size(); k++)
            chk({nm, ".rddata"}, vld_log[bv+k], dout_log[bd+4+k]);
        chk({nm, ".nrddone"}, n_done_total - bdn, 1);
        chk({nm, ".nrdfail"}, n_fail_total - bfl, 0);
        chk({nm, ".busy_at_done"}, 32'(busy_at_done), 0);
        if (vld_cyc.size() > bv)
            chk({nm, ".done_lat"}, last_done_cyc, vld_cyc[vld_cyc.size()-1] + 1);
        chk({nm, ".busy_idle"}, 32'(bus.rdbusy), 0);
    endtask

    initial begin : main
        logic [23:0] a;
        logic [7:0]  l;
        int          d0, f0;

        rst_n      = 1'b0;
        bus.rden   = 1'b0;
        bus.rdaddr = '0;
        bus.rdlen  = '0;
        repeat (3) @(negedge clk);
        chk("reset.outs", outs(), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_reset.outs", outs(), 0);

        start_read(24'h001234, 8'd4);
        wait_end("len4", 500);
        verify_read("len4", 24'h001234, 8'd4);

        a = 24'($urandom);
        start_read(a, 8'd0);
        wait_end("len256", 4000);
        verify_read("len256", a, 8'd0);

        start_read(24'hFFFFFF, 8'd1);
        wait_end("len1", 500);
        verify_read("len1", 24'hFFFFFF, 8'd1);

        // rden while busy in the ADDR phase must be ignored
        a = 24'($urandom);
        start_read(a, 8'd3);
        for (int k = 0; k < 200 && din_log.size() - bq < 2; k++) begin
            @(negedge clk);
            #1;
        end
        bus.rden   = 1'b1;
        bus.rdaddr = ~a;
        bus.rdlen  = 8'd7;
        @(negedge clk);
        #1;
        bus.rden = 1'b0;
        wait_end("busy_rden", 500);
        repeat (10) @(negedge clk);
        verify_read("busy_rden", a, 8'd3);

        // Timeout on the CMD byte
        withhold_at = req_n + 1;
        start_read(24'h0ABCDE, 8'd3);
        wait_end("timeout", TIMEOUT + 200);
        chk("timeout.nreq", din_log.size() - bq, 1);
        if (din_log.size() > bq) chk("timeout.din", din_log[bq], CMD_READ);
        chk("timeout.nrdfail", n_fail_total - bfl, 1);
        chk("timeout.nrddone", n_done_total - bdn, 0);
        chk("timeout.finish", 32'(fin_at_fail), 1);
        chk("timeout.busy", 32'(busy_at_fail), 0);
        if (req_cyc.size() > bq) chk("timeout.lat", last_fail_cyc - req_cyc[bq], TIMEOUT + 1);
        chk("timeout.nvld", vld_log.size() - bv, 0);
        chk("timeout.finish_after", 32'(bus.finish), 0);
        withhold_at = -1;

        a = 24'($urandom);
        l = 8'($urandom_range(1, 12));
        start_read(a, l);
        wait_end("after_to", 1000);
        verify_read("after_to", a, l);

        // Stray done while idle
        snap();
        spur_cnt++;
        repeat (5) @(negedge clk);
        #1;
        chk("spur.nreq", din_log.size() - bq, 0);
        chk("spur.nvld", vld_log.size() - bv, 0);
        chk("spur.busy", 32'(bus.rdbusy), 0);

        // Asynchronous reset during the second data byte
        a = 24'($urandom);
        start_read(a, 8'd4);
        for (int k = 0; k < 200 && din_log.size() - bq < 6; k++) begin
            @(negedge clk);
            #1;
        end
        chk("rst.reached_byte6", 32'(din_log.size() - bq >= 6), 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst.async_outs", outs(), 0);
        d0 = n_done_total;
        f0 = n_fail_total;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk("rst.nrddone", n_done_total - d0, 0);
        chk("rst.nrdfail", n_fail_total - f0, 0);
        chk("rst.idle_outs", outs(), 0);

        a = 24'($urandom);
        start_read(a, 8'd2);
        wait_end("post_rst", 500);
        verify_read("post_rst", a, 8'd2);

        for (int r = 0; r < 4; r++) begin
            a = 24'($urandom);
            l = 8'($urandom_range(1, 20));
            start_read(a, l);
            wait_end("rand", 2000);
            verify_read("rand", a, l);
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule

// File: doc/flash_read.md
Name: flash_read

Overview:
- SPI NOR flash read-sequence controller, the read-side sibling of flash_write.
- Sits directly upstream of spi_master and drives its byte-level req/din/finish handshake.
- On a rden pulse it issues READ DATA (0x03) plus a 24-bit address, then clocks out a programmable number of data bytes.
- Each received byte is presented to the user side with a one-cycle valid.

Parameters:
- CMD_READ, 8'h03, read command opcode.
- DUMMY_BYTE, 8'h00, value driven on din during data-phase transfers.
- TIMEOUT, 1024, max cycles to wait for done per byte before abort.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- rden  input  1  one-cycle start pulse; sampled only in IDLE.
- rdaddr  input  24  start address; latched when rden is accepted.
- rdlen  input  8  number of data bytes to read; latched with rdaddr; 0 means 256.
- rddata  output  8  received data byte.
- rddata_vld  output  1  one-cycle strobe, rddata valid.
- rdbusy  output  1  high from rden acceptance through the rddone/rdfail cycle.
- rddone  output  1  one-cycle pulse after the last byte is delivered.
- rdfail  output  1  one-cycle pulse on timeout abort.
- done  input  1  spi_master byte-complete pulse.
- dout  input  8  spi_master received byte; valid when done=1.
- req  output  1  one-cycle byte-transfer request to spi_master.
- din  output  8  byte to transmit; held stable from req until done.
- finish  output  1  high with the final byte's req, held until its done; spi_master releases cs after that byte.

Behaviour:
- Reset values: req, finish, rddata_vld, rddone, rdfail, rdbusy = 0; din, rddata = 0; all counters = 0; state = IDLE.
- States: IDLE, CMD, ADDR, DATA, END.
- Each of CMD, ADDR and DATA runs a two-phase byte cycle:
  - SEND: req=1 for exactly one cycle, din loaded in the same cycle.
  - WAIT: hold din and finish until done=1.
- IDLE:
  - rden=1 latches rdaddr and rdlen (0 maps to 256, held in a 9-bit count).
  - Sets rdbusy=1 and moves to CMD on the next cycle.
- CMD: sends din=CMD_READ; on done goes to ADDR with byte index 0.
- ADDR:
  - Sends addr[23:16], addr[15:8], addr[7:0] in that order.
  - dout is ignored during this phase.
  - After the third done goes to DATA.
- DATA:
  - Sends DUMMY_BYTE for each byte.
  - On done, rddata<=dout and rddata_vld=1 for one cycle; the remaining count decrements.
  - finish=1 accompanies the req of the last byte (remaining==1).
  - After the last done goes to END.
- END: rddone=1 for one cycle, rdbusy=0, then returns to IDLE.
- Latency:
  - First req occurs 1 cycle after rden.
  - Next req occurs 1 cycle after each done.
  - rddone occurs 1 cycle after the final rddata_vld.
- Timeout:
  - The wait counter clears on each req and increments every WAIT cycle.
  - When it reaches TIMEOUT without done: rdfail=1 for one cycle, finish=1 for that same cycle to close cs, rdbusy=0, state = IDLE.
  - No rddone is issued.
- rden while rdbusy=1 is ignored; no queueing.
- done outside WAIT is ignored.
- done in the same cycle as the timeout terminal count: done wins; the byte completes normally.
- Address does not auto-increment across commands. Within a command the flash wraps at 0xFFFFFF; the block does not track this.
- Asynchronous reset mid-operation returns to IDLE immediately with all outputs at reset values, and produces no rddone/rdfail.

Test Plan:
- rden with rdaddr=24'h001234, rdlen=4 -> din sequence 03,00,12,34,00,00,00,00; finish only on the 8th byte; rddata_vld 4 times with the model's dout values; then rddone once, and rdbusy low the same cycle.
- rdlen=0 -> exactly 256 rddata_vld pulses, then rddone; finish only on byte 260.
- rdlen=1, rdaddr=24'hFFFFFF -> din 03,FF,FF,FF,00; finish on the 5th byte; one rddata_vld.
- Second rden pulse during the ADDR phase -> ignored; the transfer completes unchanged and exactly one rddone is produced.
- spi_master stub withholds done after the CMD byte -> after 1024 wait cycles rdfail=1 with finish=1, state IDLE, no rddone; a new rden then starts normally.
- rst_n driven low during the DATA phase (byte 2 of 4) -> all outputs 0 asynchronously; after release, a fresh read of rdlen=2 completes correctly.
